// File: rtl/mm_read_pkg.sv
// mm_read_pkg: state encoding and timeout constants shared by the main-memory read requester
package mm_read_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        RELEASE = 2'b10
    } state_e;

    localparam int TMO_CNT_W       = 8;
    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mm_req_buffer.sv
// mm_req_buffer: one-entry address holding register with full flag, push and pop
module mm_req_buffer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // push only happens while empty and pop only while full, so they never collide
    always_comb begin
        full_d = push_i ? 1'b1 : (pop_i ? 1'b0 : full_q);
        addr_d = push_i ? addr_i : addr_q;
    end

    // entry and full flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            addr_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/mm_read_requester.sv
// mm_read_requester: pipeline-side requester for the level main-memory read handshake; MM_READ_TIMEOUT_EN adds an ISSUE timeout abort
module mm_read_requester
    import mm_read_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              resetIn,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mm_enable,
    output logic [ADDR_W-1:0] mm_addr,
    input  logic              mm_ack,
    input  logic [DATA_W-1:0] mm_rdata,
    output logic              stall
);

    if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be within 4..255");
    end

    state_e            state_q, state_d;
    logic              mm_enable_q, mm_enable_d;
    logic [ADDR_W-1:0] mm_addr_q, mm_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              buf_full, accept, push, pop, tmo;
    logic [ADDR_W-1:0] buf_addr;

    assign req_ready = !buf_full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && state_q != IDLE;
    assign stall     = state_q != IDLE || buf_full;

    mm_req_buffer #(.ADDR_W(ADDR_W)) u_buf (
        .clk_i  (CLOCK_50),
        .rst_ni (resetIn),
        .push_i (push),
        .pop_i  (pop),
        .addr_i (req_addr),
        .full_o (buf_full),
        .addr_o (buf_addr)
    );

`ifdef MM_READ_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
    logic                 rsp_err_q;

    // counter restarts from zero on every ISSUE entry because it idles at zero elsewhere
    assign cnt_d = (state_q == ISSUE) ? cnt_q + 1'b1 : '0;
    assign tmo   = state_q == ISSUE && !mm_ack && cnt_q == TMO_CNT_W'(TIMEOUT - 1);

    // timeout counter and error flag registers
    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= tmo;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign tmo     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // next state; RELEASE always drops mm_enable for one cycle so the handshake cannot re-arm on a stale ack
    always_comb begin
        state_d    = state_q;
        mm_addr_d  = mm_addr_q;
        rsp_data_d = rsp_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d   = ISSUE;
                mm_addr_d = req_addr;
            end
            ISSUE: if (mm_ack) begin
                state_d    = RELEASE;
                rsp_data_d = mm_rdata;
            end else if (tmo) begin
                state_d    = RELEASE;
                rsp_data_d = '0;
            end
            RELEASE: if (buf_full) begin
                state_d   = ISSUE;
                mm_addr_d = buf_addr;
                pop       = 1'b1;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mm_enable_d = state_d == ISSUE;
        rsp_valid_d = state_q == ISSUE && state_d == RELEASE;
    end

    // state and registered outputs
    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            state_q     <= IDLE;
            mm_enable_q <= 1'b0;
            mm_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mm_enable_q <= mm_enable_d;
            mm_addr_q   <= mm_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mm_enable = mm_enable_q;
    assign mm_addr   = mm_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mm_read_requester.sv
// tb_mm_read_requester: directed self-checking bench for mm_read_requester; timeout cases run when MM_READ_TIMEOUT_EN is defined
module tb_mm_read_requester;

    logic        CLOCK_50 = 1'b0;
    logic        resetIn;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready, rsp_valid, rsp_err, mm_enable, mm_ack, stall;
    logic [31:0] rsp_data, mm_addr, mm_rdata;

    logic        extra_ack;
    logic [7:0]  ack_at, mcnt;
    int          errs = 0, checks = 0;

    logic [15:0] en_tr, rsp_tr, rdy_tr, stl_tr;
    logic [31:0] at_addr [16];
    logic [31:0] d0, d1;
    logic        e0, e1;
    int          nr;
    logic        seen;

    always #5 CLOCK_50 = ~CLOCK_50;

    mm_read_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetIn   (resetIn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mm_enable (mm_enable),
        .mm_addr   (mm_addr),
        .mm_ack    (mm_ack),
        .mm_rdata  (mm_rdata),
        .stall     (stall)
    );

    // memory model: ack after ack_at consecutive enable-high cycles
    always @(posedge CLOCK_50) mcnt <= mm_enable ? mcnt + 8'd1 : 8'd0;
    assign mm_ack   = (mm_enable && mcnt == ack_at) || extra_ack;
    assign mm_rdata = (mm_addr == 32'h100) ? 32'hDEADBEEF : (mm_addr ^ 32'hA5A5_0000);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // cycle c is sampled at its start, then its inputs are driven; a request at cycle c is accepted at the edge ending it
    task automatic run(input int n, input logic [15:0] req_at, input logic [31:0] a0,
                       input logic [31:0] a1, input int ack_c);
        int nreq = 0;
        en_tr = '0; rsp_tr = '0; rdy_tr = '0; stl_tr = '0;
        nr = 0; d0 = 'x; d1 = 'x; e0 = 'x; e1 = 'x;
        for (int c = 0; c < n; c++) begin
            en_tr[c]   = mm_enable;
            rsp_tr[c]  = rsp_valid;
            rdy_tr[c]  = req_ready;
            stl_tr[c]  = stall;
            at_addr[c] = mm_addr;
            if (rsp_valid) begin
                if (nr == 0) begin d0 = rsp_data; e0 = rsp_err; end
                else begin d1 = rsp_data; e1 = rsp_err; end
                nr++;
            end
            req_valid = req_at[c];
            req_addr  = (nreq == 0) ? a0 : a1;
            if (req_at[c]) nreq++;
            extra_ack = (c == ack_c);
            tick();
        end
        req_valid = 1'b0;
        extra_ack = 1'b0;
    endtask

    initial begin
        resetIn = 1'b0; req_valid = 1'b0; req_addr = '0; extra_ack = 1'b0; ack_at = 8'd3;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_mm_enable", mm_enable, 0);
        chk("rst_mm_addr", mm_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        resetIn = 1'b1;
        tick();

        // single read: enable cycles 1..4, response cycle 5
        run(7, 16'h0001, 32'h100, 32'h0, -1);
        chk("single_en", en_tr, 16'h001E);
        chk("single_rsp", rsp_tr, 16'h0020);
        chk("single_data", d0, 32'hDEADBEEF);
        chk("single_err", e0, 0);
        chk("single_addr", at_addr[1], 32'h100);
        chk("single_nrsp", nr, 1);

        // back-to-back: second posted at cycle 2, buffered until the RELEASE at cycle 5
        run(12, 16'h0005, 32'h10, 32'h14, -1);
        chk("b2b_en", en_tr, 16'h03DE);
        chk("b2b_rsp", rsp_tr, 16'h0420);
        chk("b2b_ready", rdy_tr, 16'h0FC7);
        chk("b2b_stall", stl_tr, 16'h07FE);
        chk("b2b_addr0", at_addr[2], 32'h10);
        chk("b2b_addr1", at_addr[7], 32'h14);
        chk("b2b_data0", d0, 32'hA5A50010);
        chk("b2b_data1", d1, 32'hA5A50014);

        // stray acks in IDLE and in RELEASE are ignored
        extra_ack = 1'b1;
        tick();
        extra_ack = 1'b0;
        chk("idle_ack_rsp", rsp_valid, 0);
        chk("idle_ack_en", mm_enable, 0);
        chk("idle_ack_stall", stall, 0);
        run(9, 16'h0001, 32'h100, 32'h0, 5);
        chk("rel_ack_en", en_tr, 16'h001E);
        chk("rel_ack_rsp", rsp_tr, 16'h0020);
        chk("rel_ack_stall", stl_tr, 16'h003E);

        // asynchronous reset in ISSUE cycle 3 drops the request
        req_valid = 1'b1; req_addr = 32'h100;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("mid_en_before", mm_enable, 1);
        #2 resetIn = 1'b0;
        #1;
        chk("mid_rst_en", mm_enable, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_addr", mm_addr, 0);
        tick();
        tick();
        resetIn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen |= rsp_valid;
            tick();
        end
        chk("mid_rst_no_rsp", seen, 0);
        run(7, 16'h0001, 32'h100, 32'h0, -1);
        chk("after_rst_en", en_tr, 16'h001E);
        chk("after_rst_rsp", rsp_tr, 16'h0020);
        chk("after_rst_data", d0, 32'hDEADBEEF);

`ifdef MM_READ_TIMEOUT_EN
        // no ack: ISSUE cycles 1..8, abort response in cycle 9
        ack_at = 8'hFF;
        run(12, 16'h0001, 32'h200, 32'h0, -1);
        chk("tmo_en", en_tr, 16'h01FE);
        chk("tmo_rsp", rsp_tr, 16'h0200);
        chk("tmo_data", d0, 32'h0);
        chk("tmo_err", e0, 1);
        // ack in the timeout cycle wins
        ack_at = 8'd7;
        run(12, 16'h0001, 32'h200, 32'h0, -1);
        chk("tmo_ack_rsp", rsp_tr, 16'h0200);
        chk("tmo_ack_data", d0, 32'hA5A50200);
        chk("tmo_ack_err", e0, 0);
        ack_at = 8'd3;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mm_read_requester.md
# mm_read_requester

Upstream requester for the main-memory read handshake. Accepts read requests from the processor pipeline (fetch or memory stage), drives the level-sensitive `mm_enable` toward the main-memory read handshake, holds it until `mm_ack`, captures read data, and returns a one-cycle response. A one-entry holding buffer lets the pipeline post the next request while one is in flight. `stall` lets the pipeline freeze while memory is busy.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, read data width
- `TIMEOUT`, 16, max cycles in ISSUE before abort (used only with `MM_READ_TIMEOUT_EN`); legal range 4..255

Ports (one clock; reset is asynchronous and active-low):
- `CLOCK_50` in 1: system clock, all state on rising edge
- `resetIn` in 1: asynchronous active-low reset
- `req_valid` in 1: pipeline read request
- `req_addr` in ADDR_W: request address
- `req_ready` out 1: request accepted this cycle when `req_valid && req_ready`
- `rsp_valid` out 1: one-cycle response pulse, no backpressure
- `rsp_data` out DATA_W: read data, valid with `rsp_valid`
- `rsp_err` out 1: response was a timeout abort (constant 0 without macro)
- `mm_enable` out 1: level request to memory handshake
- `mm_addr` out ADDR_W: address, stable while `mm_enable` high
- `mm_ack` in 1: memory acknowledge (level)
- `mm_rdata` in DATA_W: memory data, valid while `mm_ack` high
- `stall` out 1: high when state ≠ IDLE or holding buffer full

## Operation
- States: IDLE, ISSUE, RELEASE.
- IDLE: `mm_enable`=0. On accepted request → latch address into `mm_addr`, go ISSUE.
- ISSUE: `mm_enable`=1, `mm_addr` held. On `mm_ack` sampled high → capture `mm_rdata`, go RELEASE.
- RELEASE: `mm_enable`=0 for exactly one cycle (the memory handshake re-arms on enable high while ack is high; the drop prevents a spurious re-issue). `rsp_valid`=1 with captured data this cycle. Next: ISSUE with buffered address if buffer full (buffer empties), else IDLE.
- Holding buffer: one entry. `req_ready` = buffer empty. In IDLE with buffer empty, an accepted request bypasses the buffer straight to ISSUE. In ISSUE/RELEASE an accepted request fills the buffer.
- Simultaneous RELEASE→ISSUE from buffer and a new `req_valid`: new request is not accepted (`req_ready` is 0 while full); it is accepted the following cycle into the now-empty buffer.
- `mm_ack` outside ISSUE is ignored.
- Reset (any time, including mid-ISSUE): state IDLE, buffer empty, `mm_enable`=0, `mm_addr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `req_ready`=1, `stall`=0. In-flight request is dropped, no response.

## Timing
- Accept in cycle 0 → `mm_enable` high cycles 1..N where N is first cycle with `mm_ack` high; against the 3-cycle memory handshake, `mm_ack` first high in cycle 4, `rsp_valid` in cycle 5.
- Request-to-response latency: handshake latency + 2 cycles; nominal 5.
- Back-to-back throughput: one response per 5 cycles (ISSUE 4 + RELEASE 1).
- `rsp_valid` never asserted on two consecutive cycles.
- All outputs registered except `req_ready` and `stall` (decoded from registered state).

## Configuration
- `MM_READ_TIMEOUT_EN` defined: 8-bit counter clears on entry to ISSUE, increments each ISSUE cycle without ack. Reaching `TIMEOUT` → go RELEASE with `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0. Ack and timeout in the same cycle: ack wins, `rsp_err`=0.
- Not defined: no counter, ISSUE waits indefinitely, `rsp_err` tied 0.

## Structure
- Package `mm_read_pkg`: state encoding (IDLE=2'b00, ISSUE=2'b01, RELEASE=2'b10), timeout counter width constant, default `TIMEOUT`.
- One sub-module: `mm_req_buffer`, the one-entry address holding register with full flag, push and pop.

## Test plan
- Single read, memory model acks 3 cycles after enable with data 0xDEADBEEF at addr 0x100 → `mm_enable` high cycles 1–4, `rsp_valid` pulse cycle 5, `rsp_data`=0xDEADBEEF, `rsp_err`=0.
- Back-to-back addr 0x10 then 0x14 (second posted cycle 2) → `req_ready` low cycles 3–5, `mm_enable` low exactly cycle 5, second ISSUE starts cycle 6, two responses at cycles 5 and 10.
- `mm_ack` pulsed while IDLE and during RELEASE → no state change, no `rsp_valid`.
- `resetIn` low in cycle 3 of ISSUE → `mm_enable`, `stall` drop asynchronously, no response; new request after release completes normally.
- With `MM_READ_TIMEOUT_EN`, `TIMEOUT`=8, ack never asserted → `rsp_valid` 8 cycles after ISSUE entry with `rsp_err`=1, `rsp_data`=0; repeat with ack on cycle 8 → `rsp_err`=0.
